// File: rtl/bus_xfer_ctrl_if.sv
// bus_xfer_ctrl_if: master-side request/data lines, shared slave bus and status
// from the transfer controller, grouped for the controller and its environment.
interface bus_xfer_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic [2:0]    gnt;
    logic [3*AW-1:0] m_addr;
    logic [11:0]   m_len;
    logic [3*DW-1:0] m_data;
    logic          bus_rdy;
    logic          bus_avalid;
    logic [AW-1:0] bus_addr;
    logic          bus_valid;
    logic [DW-1:0] bus_data;
    logic [2:0]    owner;
    logic [2:0]    m_ack;
    logic [2:0]    m_done;
    logic          busy;
    logic          err;

    modport master (
        output gnt, m_addr, m_len, m_data, bus_rdy,
        input  bus_avalid, bus_addr, bus_valid, bus_data, owner, m_ack, m_done, busy, err
    );

    modport slave (
        input  gnt, m_addr, m_len, m_data, bus_rdy,
        output bus_avalid, bus_addr, bus_valid, bus_data, owner, m_ack, m_done, busy, err
    );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: latches the granted master, muxes its address/data onto the
// shared bus and runs a counted burst with back-pressure and stall timeout.
module bus_xfer_ctrl #(
    parameter int DW  = 8,
    parameter int AW  = 8,
    parameter int TMO = 16
) (
    input logic       clk,
    input logic       rst,
    bus_xfer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, ABORT} state_t;
    localparam logic [7:0] STALL_MAX = 8'(TMO - 1);

    state_t        r_state, w_next;
    logic [2:0]    r_owner;
    logic [AW-1:0] r_addr, w_gaddr;
    logic [3:0]    r_cnt, w_glen;
    logic [7:0]    r_stall;
    logic          r_ill;
    logic [DW-1:0] w_data;
    logic          w_multi, w_one, w_valid, w_acc, w_tmo, w_end;

    // one-hot and-or muxes: live grant selects the capture, latched owner the data
    always_comb begin
        w_gaddr = '0;
        w_glen  = '0;
        w_data  = '0;
        for (int i = 0; i < 3; i++) begin
            w_gaddr = w_gaddr | (bus.m_addr[i*AW +: AW] & {AW{bus.gnt[i]}});
            w_glen  = w_glen | (bus.m_len[i*4 +: 4] & {4{bus.gnt[i]}});
            w_data  = w_data | (bus.m_data[i*DW +: DW] & {DW{r_owner[i]}});
        end
    end

    assign w_multi = |(bus.gnt & (bus.gnt - 3'd1));
    assign w_one   = (bus.gnt != 3'd0) && !w_multi;
    assign w_valid = r_state == DATA;
    assign w_acc   = w_valid && bus.bus_rdy;
    assign w_tmo   = w_valid && !bus.bus_rdy && r_stall == STALL_MAX;
    assign w_end   = r_state == DONE || r_state == ABORT;

    assign bus.bus_avalid = r_state == ADDR;
    assign bus.bus_valid  = w_valid;
    assign bus.bus_addr   = r_addr;
    assign bus.bus_data   = w_data;
    assign bus.owner      = r_owner;
    assign bus.m_ack      = r_owner & {3{w_acc}};
    assign bus.m_done     = r_owner & {3{w_end}};
    assign bus.busy       = r_state != IDLE;
    assign bus.err        = r_ill || r_state == ABORT;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_one ? ADDR : IDLE;
            ADDR:    w_next = DATA;
            DATA:    w_next = (w_acc && r_cnt == 4'd0) ? DONE : w_tmo ? ABORT : DATA;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_stall <= '0;
            r_ill   <= 1'b0;
        end else begin
            r_ill   <= r_state == IDLE && w_multi;
            r_stall <= (w_valid && !bus.bus_rdy) ? r_stall + 8'd1 : 8'd0;
            if (r_state == IDLE && w_one) begin
                r_owner <= bus.gnt;
                r_addr  <= w_gaddr;
                r_cnt   <= w_glen;
            end else if (w_acc) begin
                r_addr <= r_addr + AW'(1);
                r_cnt  <= r_cnt - 4'd1;
            end else if (w_end) begin
                r_owner <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: directed scenarios plus randomized bursts checked against a
// burst-level model (beat list, stall run length, expected end of burst).
module tb_bus_xfer_ctrl;
    localparam int DW = 8, AW = 8, TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    bus_xfer_if #(.DW(DW), .AW(AW)) bif ();
    bus_xfer_ctrl #(.DW(DW), .AW(AW), .TMO(TMO)) dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bif.gnt = '0; bif.m_addr = '0; bif.m_len = '0; bif.m_data = '0; bif.bus_rdy = 1'b0;
        #1 rst = 1'b0;
        #2;
        n_chk++;
        if ({bif.owner, bif.m_done, bif.m_ack, bif.err, bif.busy, bif.bus_avalid, bif.bus_valid,
             bif.bus_addr, bif.bus_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: owner=%b done=%b ack=%b err=%b busy=%b av=%b v=%b addr=%h data=%h, required all 0",
                     bif.owner, bif.m_done, bif.m_ack, bif.err, bif.busy, bif.bus_avalid, bif.bus_valid,
                     bif.bus_addr, bif.bus_data);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        n_chk++;
        if (bif.busy !== 1'b0 || bif.owner !== 3'b000 || bif.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b owner=%b err=%b, required 0/000/0", bif.busy, bif.owner, bif.err);
        end
    endtask

    task automatic test_single();
        bif.m_addr[AW +: AW] = 8'h10; bif.m_len[4 +: 4] = 4'd3; bif.m_data[DW +: DW] = 8'hA5;
        bif.bus_rdy = 1'b1; bif.gnt = 3'b010;
        tick();
        n_chk++;
        if (bif.bus_avalid !== 1'b1 || bif.bus_addr !== 8'h10 || bif.owner !== 3'b010 || bif.bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_addr: av=%b addr=%h owner=%b v=%b, required 1/10/010/0",
                     bif.bus_avalid, bif.bus_addr, bif.owner, bif.bus_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++;
            if (bif.bus_valid !== 1'b1 || bif.bus_addr !== 8'(8'h10 + k) || bif.m_ack !== 3'b010 || bif.bus_data !== 8'hA5) begin
                n_fail++;
                $display("FAIL single_beat%0d: v=%b addr=%h ack=%b data=%h, required 1/%h/010/a5",
                         k, bif.bus_valid, bif.bus_addr, bif.m_ack, bif.bus_data, 8'(8'h10 + k));
            end
        end
        tick();
        bif.gnt = '0;
        n_chk++;
        if (bif.m_done !== 3'b010 || bif.bus_valid !== 1'b0 || bif.err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: done=%b v=%b err=%b, required 010/0/0", bif.m_done, bif.bus_valid, bif.err);
        end
        tick();
        n_chk++;
        if (bif.busy !== 1'b0 || bif.owner !== 3'b000 || bif.m_done !== 3'b000) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b owner=%b done=%b, required 0/000/000", bif.busy, bif.owner, bif.m_done);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] pat;
        int acc;
        pat = 5'b10010;
        acc = 0;
        bif.m_addr[0 +: AW] = 8'h20; bif.m_len[0 +: 4] = 4'd1; bif.m_data[0 +: DW] = 8'h3C;
        bif.bus_rdy = 1'b0; bif.gnt = 3'b001;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            bif.bus_rdy = pat[k];
            #1;
            n_chk++;
            if (bif.bus_valid !== 1'b1 || bif.m_ack !== (pat[k] ? 3'b001 : 3'b000) || bif.err !== 1'b0 ||
                bif.bus_addr !== 8'(8'h20 + acc)) begin
                n_fail++;
                $display("FAIL bp_cycle%0d: v=%b ack=%b err=%b addr=%h, required 1/%b/0/%h",
                         k, bif.bus_valid, bif.m_ack, bif.err, bif.bus_addr, pat[k] ? 3'b001 : 3'b000, 8'(8'h20 + acc));
            end
            acc += int'(pat[k]);
        end
        tick();
        bif.gnt = '0; bif.bus_rdy = 1'b0;
        #1;
        n_chk++;
        if (bif.m_done !== 3'b001 || bif.err !== 1'b0 || bif.bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: done=%b err=%b v=%b, required 001/0/0", bif.m_done, bif.err, bif.bus_valid);
        end
        tick();
        n_chk++;
        if (bif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: busy=%b, required 0", bif.busy);
        end
    endtask

    task automatic test_timeout();
        bif.m_addr[2*AW +: AW] = 8'h80; bif.m_len[8 +: 4] = 4'($urandom_range(0, 15));
        bif.bus_rdy = 1'b0; bif.gnt = 3'b100;
        tick();
        for (int k = 0; k < TMO; k++) begin
            tick();
            n_chk++;
            if (bif.bus_valid !== 1'b1 || bif.err !== 1'b0 || bif.m_done !== 3'b000 || bif.m_ack !== 3'b000) begin
                n_fail++;
                $display("FAIL tmo_stall%0d: v=%b err=%b done=%b ack=%b, required 1/0/000/000",
                         k, bif.bus_valid, bif.err, bif.m_done, bif.m_ack);
            end
        end
        tick();
        bif.gnt = '0;
        n_chk++;
        if (bif.err !== 1'b1 || bif.m_done !== 3'b100 || bif.bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_abort: err=%b done=%b v=%b, required 1/100/0", bif.err, bif.m_done, bif.bus_valid);
        end
        tick();
        n_chk++;
        if (bif.owner !== 3'b000 || bif.err !== 1'b0 || bif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_idle: owner=%b err=%b busy=%b, required 000/0/0", bif.owner, bif.err, bif.busy);
        end
    endtask

    task automatic test_illegal_grant();
        bif.gnt = 3'b011;
        tick();
        bif.gnt = '0;
        n_chk++;
        if (bif.err !== 1'b1 || bif.owner !== 3'b000 || bif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_err: err=%b owner=%b busy=%b, required 1/000/0", bif.err, bif.owner, bif.busy);
        end
        tick();
        n_chk++;
        if (bif.err !== 1'b0 || bif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse: err=%b busy=%b, required 0/0", bif.err, bif.busy);
        end
        bif.m_addr[0 +: AW] = 8'h33; bif.m_len[0 +: 4] = 4'd0; bif.m_data[0 +: DW] = 8'hC3;
        bif.bus_rdy = 1'b1; bif.gnt = 3'b001;
        tick();
        n_chk++;
        if (bif.owner !== 3'b001 || bif.bus_avalid !== 1'b1 || bif.bus_addr !== 8'h33) begin
            n_fail++;
            $display("FAIL illegal_then_ok: owner=%b av=%b addr=%h, required 001/1/33", bif.owner, bif.bus_avalid, bif.bus_addr);
        end
        tick();
        n_chk++;
        if (bif.m_ack !== 3'b001 || bif.bus_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL illegal_then_beat: ack=%b data=%h, required 001/c3", bif.m_ack, bif.bus_data);
        end
        tick();
        bif.gnt = '0;
        n_chk++;
        if (bif.m_done !== 3'b001 || bif.err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_then_done: done=%b err=%b, required 001/0", bif.m_done, bif.err);
        end
        tick();
    endtask

    task automatic test_wrap_churn();
        bif.m_addr[0 +: AW] = 8'hFE; bif.m_len[0 +: 4] = 4'd2; bif.m_data[0 +: DW] = 8'h5E;
        bif.m_addr[2*AW +: AW] = 8'h11; bif.m_data[2*DW +: DW] = 8'hE2;
        bif.bus_rdy = 1'b1; bif.gnt = 3'b001;
        tick();
        bif.gnt = 3'b100;
        n_chk++;
        if (bif.bus_addr !== 8'hFE || bif.owner !== 3'b001) begin
            n_fail++;
            $display("FAIL wrap_addr: addr=%h owner=%b, required fe/001", bif.bus_addr, bif.owner);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (bif.bus_addr !== 8'(8'hFE + k) || bif.owner !== 3'b001 || bif.m_ack !== 3'b001 || bif.bus_data !== 8'h5E) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: addr=%h owner=%b ack=%b data=%h, required %h/001/001/5e",
                         k, bif.bus_addr, bif.owner, bif.m_ack, bif.bus_data, 8'(8'hFE + k));
            end
        end
        tick();
        bif.gnt = '0;
        n_chk++;
        if (bif.m_done !== 3'b001) begin
            n_fail++;
            $display("FAIL wrap_done: done=%b, required 001", bif.m_done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bif.m_addr[0 +: AW] = 8'h60; bif.m_len[0 +: 4] = 4'd3; bif.m_data[0 +: DW] = 8'h77;
        bif.bus_rdy = 1'b1; bif.gnt = 3'b001;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        n_chk++;
        if ({bif.owner, bif.m_done, bif.m_ack, bif.err, bif.busy, bif.bus_avalid, bif.bus_valid,
             bif.bus_addr, bif.bus_data} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: owner=%b done=%b ack=%b err=%b busy=%b v=%b addr=%h data=%h, required all 0",
                     bif.owner, bif.m_done, bif.m_ack, bif.err, bif.busy, bif.bus_valid, bif.bus_addr, bif.bus_data);
        end
        bif.gnt = '0;
        tick();
        n_chk++;
        if (bif.m_done !== 3'b000 || bif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_nodone: done=%b busy=%b, required 000/0", bif.m_done, bif.busy);
        end
        rst = 1'b1;
        bif.m_addr[2*AW +: AW] = 8'h40; bif.m_len[8 +: 4] = 4'd0; bif.m_data[2*DW +: DW] = 8'h5A;
        bif.gnt = 3'b100;
        tick();
        n_chk++;
        if (bif.bus_avalid !== 1'b1 || bif.bus_addr !== 8'h40 || bif.owner !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid_regrant: av=%b addr=%h owner=%b, required 1/40/100", bif.bus_avalid, bif.bus_addr, bif.owner);
        end
        tick();
        n_chk++;
        if (bif.m_ack !== 3'b100 || bif.bus_data !== 8'h5A || bif.bus_addr !== 8'h40) begin
            n_fail++;
            $display("FAIL rstmid_beat: ack=%b data=%h addr=%h, required 100/5a/40", bif.m_ack, bif.bus_data, bif.bus_addr);
        end
        tick();
        bif.gnt = '0;
        n_chk++;
        if (bif.m_done !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid_done: done=%b, required 100", bif.m_done);
        end
        tick();
    endtask

    task automatic test_random();
        int m, len, p, k, st, cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic r;
        bit ab, fin;
        for (int it = 0; it < 40; it++) begin
            m   = $urandom_range(0, 2);
            len = $urandom_range(0, 15);
            a   = AW'($urandom);
            d   = DW'($urandom);
            case ($urandom_range(0, 3))
                0:       p = 0;
                1:       p = 30;
                2:       p = 70;
                default: p = 100;
            endcase
            bif.m_data = 24'($urandom); bif.m_data[m*DW +: DW] = d;
            bif.m_addr = 24'($urandom); bif.m_addr[m*AW +: AW] = a;
            bif.m_len  = 12'($urandom); bif.m_len[m*4 +: 4] = 4'(len);
            bif.gnt    = 3'(1 << m);
            tick();
            n_chk++;
            if (bif.bus_avalid !== 1'b1 || bif.bus_addr !== a || bif.owner !== 3'(1 << m)) begin
                n_fail++;
                $display("FAIL rnd%0d_addr: av=%b addr=%h owner=%b, required 1/%h/%b",
                         it, bif.bus_avalid, bif.bus_addr, bif.owner, a, 3'(1 << m));
            end
            bif.gnt = 3'($urandom);
            bif.m_len = 12'($urandom);
            bif.m_addr[m*AW +: AW] = AW'($urandom);
            k = 0; st = 0; ab = 1'b0; fin = 1'b0; cyc = 0;
            while (!fin && cyc < 600) begin
                tick();
                cyc++;
                r = $urandom_range(0, 99) < p;
                bif.bus_rdy = r;
                #1;
                n_chk++;
                if (bif.bus_valid !== 1'b1 || bif.err !== 1'b0 || bif.m_done !== 3'b000 ||
                    bif.bus_addr !== AW'(a + k) || bif.bus_data !== d || bif.m_ack !== (r ? 3'(1 << m) : 3'b000)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_data: v=%b err=%b done=%b addr=%h data=%h ack=%b, required 1/0/000/%h/%h/%b",
                             it, bif.bus_valid, bif.err, bif.m_done, bif.bus_addr, bif.bus_data, bif.m_ack,
                             AW'(a + k), d, r ? 3'(1 << m) : 3'b000);
                end
                if (r) begin
                    k++;
                    st  = 0;
                    fin = k == len + 1;
                end else begin
                    st++;
                    ab  = st == TMO;
                    fin = ab;
                end
            end
            n_chk++;
            if (!fin) begin
                n_fail++;
                $display("FAIL rnd%0d_budget: burst still open after %0d cycles, required end", it, cyc);
            end
            tick();
            bif.gnt = '0;
            n_chk++;
            if (bif.m_done !== 3'(1 << m) || bif.err !== ab || bif.bus_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_end: done=%b err=%b v=%b, required %b/%b/0",
                         it, bif.m_done, bif.err, bif.bus_valid, 3'(1 << m), ab);
            end
            tick();
            n_chk++;
            if (bif.busy !== 1'b0 || bif.owner !== 3'b000 || bif.m_done !== 3'b000 || bif.err !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_idle: busy=%b owner=%b done=%b err=%b, required 0/000/000/0",
                         it, bif.busy, bif.owner, bif.m_done, bif.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_timeout();
        test_illegal_grant();
        test_wrap_churn();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Downstream consumer of the 3-master bus arbiter's one-hot grant vector.
- Latches the granted master as bus owner and muxes that master's address and data onto the shared slave bus.
- Runs a counted burst with slave back-pressure and a stall timeout, then pulses a per-master done so the master drops its request and the arbiter can re-grant.

Parameters:
- DW, 8, data width per master and on the shared bus.
- AW, 8, address width per master and on the shared bus.
- TMO, 16, consecutive stalled DATA cycles before a timeout abort (legal range 2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- gnt  input  3  one-hot grant from the arbiter; bit i = master i.
- m_addr  input  3*AW  start addresses; master i at [i*AW +: AW].
- m_len  input  12  burst length minus 1; master i at [i*4 +: 4]; 0 = 1 beat, 15 = 16 beats.
- m_data  input  3*DW  write data; master i at [i*DW +: DW].
- bus_rdy  input  1  slave accepts the current data beat.
- bus_avalid  output  1  address phase valid.
- bus_addr  output  AW  owner's address, incremented by 1 per accepted beat.
- bus_valid  output  1  data beat valid.
- bus_data  output  DW  owner's m_data, combinational mux.
- owner  output  3  one-hot latched owner; 000 when idle.
- m_ack  output  3  combinational: owner & {3{bus_valid & bus_rdy}}.
- m_done  output  3  1-cycle pulse on the owner bit at burst end.
- busy  output  1  high in every state except IDLE.
- err  output  1  1-cycle pulse on timeout or illegal grant.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. owner, m_done, err, bus_avalid, bus_valid, the beat counter, the stall counter and the address register are all 0.
- States are IDLE, ADDR, DATA, DONE, ABORT.
- IDLE:
  - gnt exactly one-hot at a rising edge: latch owner=gnt, addr register=m_addr[owner], beat count=m_len[owner]; go to ADDR.
  - gnt multi-hot at a rising edge: stay in IDLE, err=1 for one cycle, no capture.
  - gnt=000: stay in IDLE.
- ADDR: exactly one cycle with bus_avalid=1 and bus_addr valid; go to DATA.
- DATA:
  - bus_valid=1.
  - A beat is accepted when bus_valid & bus_rdy. On each accepted beat: m_ack[owner]=1 in the same cycle; addr register +1, wrapping modulo 2^AW; the beat counter decrements.
  - Accepting the beat with counter=0 goes to DONE.
  - The stall counter increments on every DATA cycle with bus_rdy=0 and clears on any accepted beat. When it reaches TMO-1 with bus_rdy still 0, go to ABORT.
- DONE: one cycle, m_done[owner]=1, bus_valid=0; then IDLE with owner=000.
- ABORT: one cycle, err=1, m_done[owner]=1, bus_valid=0; then IDLE with owner=000.
- Latency with bus_rdy tied to 1: grant sampled at edge N; ADDR in cycle N+1; beats in N+2 .. N+2+len; DONE at N+3+len; a new grant is accepted in the IDLE cycle N+4+len.
- gnt changing or dropping while busy is ignored; owner stays latched until DONE or ABORT. m_len and m_addr are sampled only in IDLE.
- bus_rdy=1 in the final beat and the timeout threshold in the same cycle: the beat wins and the FSM goes to DONE.
- Reset asserted mid-burst: immediate return to reset values; no m_done pulse is issued.
- Outputs bus_addr and bus_data are don't-care when their valid is 0; bus_data is still driven from the owner mux, and is 0 when owner=000.

Test Plan:
- Single master: gnt=010, m_len[1]=3, m_addr[1]=0x10, bus_rdy=1 -> 4 beats with bus_addr 0x10..0x13; m_ack=010 on each beat; m_done=010 at cycle N+6; busy low at N+7.
- Back-pressure: gnt=001, m_len=1, bus_rdy toggles 0,1,0,0,1 -> exactly 2 beats accepted; m_ack only on bus_rdy=1 cycles; no err.
- Timeout: TMO=16, gnt=100, bus_rdy held 0 -> err and m_done=100 pulse after 16 stalled DATA cycles; owner=000 the following cycle.
- Illegal grant: gnt=011 in IDLE -> err pulse for one cycle, owner stays 000, busy stays 0. Then gnt=001 -> normal burst.
- Grant churn and wrap: gnt switches 001 -> 100 mid-burst with m_addr[0]=0xFE, m_len[0]=2 -> owner stays 001; bus_addr sequence is 0xFE, 0xFF, 0x00.
- Reset mid-burst: rst=0 during beat 2 of 4 -> all outputs 0 immediately; no m_done; the next grant after rst=1 starts cleanly.
